vga_sync_gen: RTL



---
 rtl/vga_sync_gen_pkg.sv | 25 ++
 rtl/vga_sync_gen_if.sv | 22 ++
 rtl/vga_sync_gen_pixel_tick_div.sv | 28 ++
 rtl/vga_sync_gen.sv | 97 +++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480 @ 60 Hz timing constants and coordinate type for the
// display path; game-object blocks import this for the visible area size.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_HD = 640;
  localparam int VGA_HF = 16;
  localparam int VGA_HS = 96;
  localparam int VGA_HB = 48;
  localparam int VGA_VD = 480;
  localparam int VGA_VF = 10;
  localparam int VGA_VS = 2;
  localparam int VGA_VB = 33;
  localparam int VGA_HT = VGA_HD + VGA_HF + VGA_HS + VGA_HB;
  localparam int VGA_VT = VGA_VD + VGA_VF + VGA_VS + VGA_VB;

  typedef logic [COORD_W-1:0] coord_t;

  // True when v lies in the inclusive window [lo, hi].
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: the generator drives it, renderer/game blocks read it.
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_tick;
  logic   frame_tick;

  modport master (
    output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_tick, frame_tick
  );

  modport slave (
    input p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_tick, frame_tick
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Pixel-rate divider: one-clk p_tick every CLK_DIV system clocks.
// With CLK_DIV=1 the counter sits at 0 and p_tick is permanently high.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt_r;

  // Divider phase counter, 0..CLK_DIV-1, restarts at phase 0 on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 4'd0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= 4'd0;
    end else begin
      div_cnt_r <= div_cnt_r + 4'd1;
    end
  end

  assign p_tick = (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync and
// video_on decoded from next-state counters, plus line/frame strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   HD       = VGA_HD,
  parameter int   HF       = VGA_HF,
  parameter int   HS       = VGA_HS,
  parameter int   HB       = VGA_HB,
  parameter int   VD       = VGA_VD,
  parameter int   VF       = VGA_VF,
  parameter int   VS       = VGA_VS,
  parameter int   VB       = VGA_VB,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam coord_t X_LAST = COORD_W'(HD + HF + HS + HB - 1);
  localparam coord_t Y_LAST = COORD_W'(VD + VF + VS + VB - 1);
  localparam coord_t HD_C   = COORD_W'(HD);
  localparam coord_t VD_C   = COORD_W'(VD);
  localparam coord_t HS_LO  = COORD_W'(HD + HF);
  localparam coord_t HS_HI  = COORD_W'(HD + HF + HS - 1);
  localparam coord_t VS_LO  = COORD_W'(VD + VF);
  localparam coord_t VS_HI  = COORD_W'(VD + VF + VS - 1);

  logic   p_tick_s;
  logic   line_tick_s;
  logic   frame_tick_s;
  coord_t x_r, y_r;
  coord_t x_nxt_s, y_nxt_s;
  logic   hsync_r, vsync_r, video_on_r;
  logic   hsync_nxt_s, vsync_nxt_s, video_on_nxt_s;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick_s)
  );

  assign line_tick_s  = p_tick_s && (x_r == X_LAST);
  assign frame_tick_s = line_tick_s && (y_r == Y_LAST);

  // Next raster position and the sync/blank levels that belong to it.
  always_comb begin
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    if (p_tick_s) begin
      if (x_r == X_LAST) begin
        x_nxt_s = '0;
        if (y_r == Y_LAST) begin
          y_nxt_s = '0;
        end else begin
          y_nxt_s = y_r + 10'd1;
        end
      end else begin
        x_nxt_s = x_r + 10'd1;
      end
    end else begin
      x_nxt_s = x_r;
    end
    hsync_nxt_s    = in_window(x_nxt_s, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt_s    = in_window(y_nxt_s, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    video_on_nxt_s = (x_nxt_s < HD_C) && (y_nxt_s < VD_C);
  end

  // Counters and decoded outputs load together so they always agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r        <= '0;
      y_r        <= '0;
      hsync_r    <= ~SYNC_POL;
      vsync_r    <= ~SYNC_POL;
      video_on_r <= 1'b1;
    end else begin
      x_r        <= x_nxt_s;
      y_r        <= y_nxt_s;
      hsync_r    <= hsync_nxt_s;
      vsync_r    <= vsync_nxt_s;
      video_on_r <= video_on_nxt_s;
    end
  end

  assign vga.p_tick     = p_tick_s;
  assign vga.pixel_x    = x_r;
  assign vga.pixel_y    = y_r;
  assign vga.hsync      = hsync_r;
  assign vga.vsync      = vsync_r;
  assign vga.video_on   = video_on_r;
  assign vga.line_tick  = line_tick_s;
  assign vga.frame_tick = frame_tick_s;

endmodule
